frv_core_fetch_request: RTL and testbench

FRV_CORE_FETCH_REQUEST -- requirements
Module: frv_core_fetch_request

---
 rtl/frv_core_fetch_request_pkg.sv | 22 ++
 rtl/frv_core_fetch_request_if.sv | 28 ++
 rtl/frv_core_fetch_rsp_fifo.sv | 45 ++++
 rtl/frv_core_fetch_request.sv | 162 ++++++++++++++++
 tb/tb_frv_core_fetch_request.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/frv_core_fetch_request_pkg.sv
// Shared core definitions for the instruction fetch request path:
// datapath width, reset PC and the buffered response entry.
package frv_core_fetch_request_pkg;

    localparam int unsigned XL             = 31;
    localparam int unsigned WA_W           = XL - 1;
    localparam int unsigned RSP_FIFO_DEPTH = 2;

    localparam logic [XL:0] FRV_PC_RESET_VALUE = 32'h0000_0000;

    typedef struct packed {
        logic [XL:0] data;
        logic        err;
        logic        half;
    } rsp_entry_t;

    // Occupancy of the 2-entry response FIFO from its status flags.
    function automatic logic [1:0] fifo_count(input logic full, input logic empty);
        return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    endfunction

endpackage

// File: rtl/frv_core_fetch_request_if.sv
// Instruction-memory request/response bus plus the fetch-buffer delivery port.
interface frv_core_fetch_request_if;
    import frv_core_fetch_request_pkg::*;

    logic        imem_req;
    logic        imem_gnt;
    logic [XL:0] imem_addr;
    logic        imem_recv;
    logic        imem_error;
    logic [XL:0] imem_rdata;

    logic        f_4byte;
    logic        f_2byte;
    logic        f_err;
    logic [XL:0] f_in;
    logic        f_ready;

    modport master (
        output imem_req, imem_addr, f_4byte, f_2byte, f_err, f_in,
        input  imem_gnt, imem_recv, imem_error, imem_rdata, f_ready
    );

    modport slave (
        input  imem_req, imem_addr, f_4byte, f_2byte, f_err, f_in,
        output imem_gnt, imem_recv, imem_error, imem_rdata, f_ready
    );

endinterface

// File: rtl/frv_core_fetch_rsp_fifo.sv
// Two-entry in-order FIFO buffering fetch responses the fetch buffer could not take.
module frv_core_fetch_rsp_fifo
    import frv_core_fetch_request_pkg::*;
(
    input  logic       g_clk,
    input  logic       g_reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_clear,
    input  rsp_entry_t i_data,
    output logic       o_full,
    output logic       o_empty,
    output rsp_entry_t o_head
);

    localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    rsp_entry_t           r_mem [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    always_ff @(posedge g_clk) begin
        if (g_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge g_clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = (r_count == CNT_W'(RSP_FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/frv_core_fetch_request.sv
// Instruction fetch request generator: issues word fetches, tracks in-flight
// responses, drops stale ones after a control-flow change and feeds the fetch buffer.
module frv_core_fetch_request
    import frv_core_fetch_request_pkg::*;
#(
    parameter logic [XL:0] PC_RESET     = FRV_PC_RESET_VALUE,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                        g_clk,
    input  logic                        g_reset,
    input  logic                        cf_req,
    input  logic [XL:0]                 cf_target,
    frv_core_fetch_request_if.master    fbus
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 2);

    logic [WA_W-1:0]  r_fetch_addr;
    logic [WA_W-1:0]  r_redir_addr;
    logic             r_redir;
    logic             r_req_hold;
    logic             r_halted;
    logic             r_half_pending;
    logic             r_half_rsp;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    rsp_entry_t       w_head;
    rsp_entry_t       w_rsp_entry;
    rsp_entry_t       w_out;
    logic [CNT_W:0]   w_inflight;
    logic             w_req;
    logic             w_grant;
    logic             w_new_grant;
    logic             w_rsp_valid;
    logic             w_rsp_keep;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_deliver;
    logic             w_disc_dec;
    logic             w_unused_tgt;

    assign w_unused_tgt = cf_target[0];

    assign w_inflight = (CNT_W+1)'(r_outstanding)
                      + (CNT_W+1)'(fifo_count(w_fifo_full, w_fifo_empty));

    // An ungranted request is held even across cf_req or a newly set halt.
    assign w_req = !g_reset &&
                   (r_req_hold || (!r_halted && (w_inflight < (CNT_W+1)'(MAX_INFLIGHT))));
    assign w_grant     = w_req && fbus.imem_gnt;
    assign w_new_grant = w_grant && !r_redir && !cf_req;

    // Responses with nothing outstanding (e.g. right after reset) are ignored.
    assign w_rsp_valid = !g_reset && fbus.imem_recv && (r_outstanding != '0);
    assign w_disc_dec  = w_rsp_valid && (r_discard != '0);
    assign w_rsp_keep  = w_rsp_valid && (r_discard == '0) && !cf_req;

    assign w_rsp_entry = '{data: fbus.imem_rdata, err: fbus.imem_error, half: r_half_rsp};

    assign w_bypass  = w_rsp_keep && w_fifo_empty && fbus.f_ready;
    assign w_push    = w_rsp_keep && !w_bypass;
    assign w_pop     = !g_reset && !cf_req && !w_fifo_empty && fbus.f_ready;
    assign w_deliver = w_pop || w_bypass;
    assign w_out     = w_fifo_empty ? w_rsp_entry : w_head;

    assign fbus.imem_req  = w_req;
    assign fbus.imem_addr = {r_fetch_addr, 2'b00};
    assign fbus.f_4byte   = w_deliver && !w_out.half;
    assign fbus.f_2byte   = w_deliver && w_out.half;
    assign fbus.f_err     = w_deliver && w_out.err;
    assign fbus.f_in      = w_out.data;

    frv_core_fetch_rsp_fifo u_rsp_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (cf_req),
        .i_data  (w_rsp_entry),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Redirect taken while a request waits for grant is deferred until that grant.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_fetch_addr <= PC_RESET[XL:2];
            r_redir_addr <= '0;
            r_redir      <= 1'b0;
        end else if (cf_req) begin
            if (w_req && !fbus.imem_gnt) begin
                r_redir      <= 1'b1;
                r_redir_addr <= cf_target[XL:2];
            end else begin
                r_fetch_addr <= cf_target[XL:2];
                r_redir      <= 1'b0;
            end
        end else if (w_grant) begin
            if (r_redir) begin
                r_fetch_addr <= r_redir_addr;
                r_redir      <= 1'b0;
            end else begin
                r_fetch_addr <= r_fetch_addr + WA_W'(1);
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_req_hold    <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_req_hold    <= w_req && !fbus.imem_gnt;
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp_valid);
        end
    end

    // Everything still in flight at a redirect belongs to the old stream.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_discard <= '0;
        end else if (cf_req) begin
            r_discard <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp_valid);
        end else begin
            r_discard <= r_discard - CNT_W'(w_disc_dec) + CNT_W'(w_grant && r_redir);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_halted <= 1'b0;
        end else if (cf_req) begin
            r_halted <= 1'b0;
        end else if (w_deliver && w_out.err) begin
            r_halted <= 1'b1;
        end
    end

    // The first new-stream response is the one carrying the half flag.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_half_pending <= 1'b0;
            r_half_rsp     <= 1'b0;
        end else if (cf_req) begin
            r_half_pending <= cf_target[1];
            r_half_rsp     <= 1'b0;
        end else begin
            if (w_new_grant) r_half_pending <= 1'b0;
            if (w_new_grant && r_half_pending) begin
                r_half_rsp <= 1'b1;
            end else if (w_rsp_keep) begin
                r_half_rsp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frv_core_fetch_request.sv
// Directed, table-driven bench for the fetch request block.
module tb_frv_core_fetch_request;

    typedef struct {
        logic        rst;
        logic        cf;
        logic [31:0] tgt;
        logic        gnt;
        logic        recv;
        logic        err;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_f4;
        logic        e_f2;
        logic        e_ferr;
        logic [31:0] e_fin;
    } vec_t;

    logic        g_clk;
    logic        g_reset;
    logic        cf_req;
    logic [31:0] cf_target;
    int          checks;
    int          errors;
    vec_t        vq[$];

    frv_core_fetch_request_if fbus ();

    frv_core_fetch_request #(
        .PC_RESET     (32'h0000_1000),
        .MAX_INFLIGHT (2)
    ) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .cf_req    (cf_req),
        .cf_target (cf_target),
        .fbus      (fbus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic add(input logic rst, input logic cf, input logic [31:0] tgt,
                       input logic gnt, input logic recv, input logic err,
                       input logic [31:0] rdata, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_f4, input logic e_f2, input logic e_ferr,
                       input logic [31:0] e_fin);
        vec_t v;
        v.rst = rst; v.cf = cf; v.tgt = tgt; v.gnt = gnt; v.recv = recv; v.err = err;
        v.rdata = rdata; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_f4 = e_f4; v.e_f2 = e_f2; v.e_ferr = e_ferr; v.e_fin = e_fin;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic cf, input logic [31:0] tgt,
                         input logic gnt, input logic recv, input logic err,
                         input logic [31:0] rdata, input logic rdy);
        g_reset         = rst;
        cf_req          = cf;
        cf_target       = tgt;
        fbus.imem_gnt   = gnt;
        fbus.imem_recv  = recv;
        fbus.imem_error = err;
        fbus.imem_rdata = rdata;
        fbus.f_ready    = rdy;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        //   rst cf tgt            gnt recv err rdata          rdy  req addr           f4 f2 fe fin
        add(1, 0, 32'h0,          0, 0, 0, 32'h0,          0,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_1000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1000,  1,   1, 32'h0000_1004,  1, 0, 0, 32'hD000_1000);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1004,  1,   1, 32'h0000_1008,  1, 0, 0, 32'hD000_1004);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1008,  1,   1, 32'h0000_100C,  1, 0, 0, 32'hD000_1008);
        // stall the fetch buffer
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_100C,  0,   1, 32'h0000_1010,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1010,  0,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          0,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   0, 32'h0,          1, 0, 0, 32'hD000_100C);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_1014,  1, 0, 0, 32'hD000_1010);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1014,  1,   1, 32'h0000_1018,  1, 0, 0, 32'hD000_1014);
        // redirect to an odd halfword with two in flight
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_101C,  0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_2002,  1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1018,  1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_101C,  1,   1, 32'h0000_2000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_2000,  1,   1, 32'h0000_2004,  0, 1, 0, 32'hD000_2000);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_2004,  1,   1, 32'h0000_2008,  1, 0, 0, 32'hD000_2004);
        // error response halts requests until the next redirect
        add(0, 0, 32'h0,          1, 1, 1, 32'hD000_2008,  1,   1, 32'h0000_200C,  1, 0, 1, 32'hD000_2008);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_200C,  1,   0, 32'h0,          1, 0, 0, 32'hD000_200C);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_3000,  1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_3000,  0, 0, 0, 32'h0);
        // redirect while a request waits for grant
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_3000,  1,   1, 32'h0000_3004,  1, 0, 0, 32'hD000_3000);
        add(0, 1, 32'h0000_4000,  0, 0, 0, 32'h0,          1,   1, 32'h0000_3004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 0, 0, 32'h0,          1,   1, 32'h0000_3004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_3004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_3004,  1,   1, 32'h0000_4000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_4000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_4000,  1,   1, 32'h0000_4004,  1, 0, 0, 32'hD000_4000);
        // redirect coinciding with a response, one outstanding
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          0,   1, 32'h0000_4004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_4004,  0,   1, 32'h0000_4008,  0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_5000,  1, 1, 0, 32'hD000_4008,  1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_5000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_5000,  1,   1, 32'h0000_5004,  1, 0, 0, 32'hD000_5000);
        // reset mid-flight; the abandoned response is ignored
        add(1, 0, 32'h0,          1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_5004,  1,   1, 32'h0000_1000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_1000,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_1000,  1,   1, 32'h0000_1004,  1, 0, 0, 32'hD000_1000);
        // address wrap at the top of the space
        add(0, 1, 32'hFFFF_FFFD,  0, 0, 0, 32'h0,          1,   1, 32'h0000_1004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 0, 0, 32'h0,          1,   1, 32'h0000_1004,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hD000_1004,  1,   1, 32'hFFFF_FFFC,  0, 0, 0, 32'h0);
        add(0, 0, 32'h0,          1, 1, 0, 32'hDFFF_FFFC,  1,   1, 32'h0000_0000,  1, 0, 0, 32'hDFFF_FFFC);
        add(0, 0, 32'h0,          0, 1, 0, 32'hD000_0000,  1,   1, 32'h0000_0004,  1, 0, 0, 32'hD000_0000);

        foreach (vq[i]) begin
            @(negedge g_clk);
            drive(vq[i].rst, vq[i].cf, vq[i].tgt, vq[i].gnt, vq[i].recv, vq[i].err,
                  vq[i].rdata, vq[i].rdy);
            #1;
            chk("imem_req", i, 32'(fbus.imem_req), 32'(vq[i].e_req));
            if (vq[i].e_req) chk("imem_addr", i, fbus.imem_addr, vq[i].e_addr);
            chk("f_4byte", i, 32'(fbus.f_4byte), 32'(vq[i].e_f4));
            chk("f_2byte", i, 32'(fbus.f_2byte), 32'(vq[i].e_f2));
            chk("f_err", i, 32'(fbus.f_err), 32'(vq[i].e_ferr));
            if (vq[i].e_f4 || vq[i].e_f2) chk("f_in", i, fbus.f_in, vq[i].e_fin);
        end

        // Stalled buffer: two words parked, requests stay off, then drain in order.
        @(negedge g_clk); drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
        @(negedge g_clk); drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 0); #1;
        chk("seq_req_a", 100, 32'(fbus.imem_req), 32'd1);
        chk("seq_addr_a", 100, fbus.imem_addr, 32'h0000_1000);
        @(negedge g_clk); drive(0, 0, 32'h0, 1, 1, 0, 32'hCAFE_0000, 0); #1;
        chk("seq_addr_b", 101, fbus.imem_addr, 32'h0000_1004);
        @(negedge g_clk); drive(0, 0, 32'h0, 1, 1, 0, 32'hCAFE_0004, 0); #1;
        chk("seq_req_c", 102, 32'(fbus.imem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge g_clk); drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 0); #1;
            chk("seq_stall_req", 103 + k, 32'(fbus.imem_req), 32'd0);
            chk("seq_stall_out", 103 + k, 32'(fbus.f_4byte | fbus.f_2byte), 32'd0);
        end
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                @(negedge g_clk); drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 1); #1;
                if (fbus.f_4byte) begin
                    seen = 1'b1;
                    chk("seq_drain0", 110, fbus.f_in, 32'hCAFE_0000);
                end
            end
            if (!seen) chk("seq_drain_timeout", 110, 32'd0, 32'd1);
        end
        @(negedge g_clk); drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 1); #1;
        chk("seq_drain1_f4", 111, 32'(fbus.f_4byte), 32'd1);
        chk("seq_drain1", 111, fbus.f_in, 32'hCAFE_0004);
        chk("seq_resume", 111, 32'(fbus.imem_req), 32'd1);
        chk("seq_resume_addr", 111, fbus.imem_addr, 32'h0000_1008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
